// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
// Sequences spi_ad7324 conversion frames across the four converter channels
// (0 Vout, 1 Temp, 2 Vin, 3 Iout). It issues one frame at a time and checks
// the returned channel ID. It converts the 13-bit two's-complement result to
// offset binary and keeps the top M+1 bits per channel. Round-robin scanning
// is interleaved with urgent Vout requests from the compensator.
//
// Ports:
//   CLK        20 MHz system clock (CLK20M)
//   RSTn       asynchronous active-low reset
//   EN         scan enable (level)
//   CH_MASK    per-channel enable, bit0 Vout .. bit3 Iout
//   PRIO_REQ   urgent Vout sample request (pulse or level)
//   DATA_READ  frame result: [14:13] channel ID, [12:0] two's-complement data
//   SPI_RSTp   active-high reset to spi_ad7324
//   SPI_HOLD   one-cycle frame start pulse
//   SPI_CH     channel address of the current frame
//   Vout/Temp/Vin/Iout  latest converted result per channel
//   VALID      one-cycle pulse per channel on result update
//   CH_ERR     one-cycle pulse on channel-ID mismatch
//   BUSY       high from frame start through capture
module adc_scan_scheduler #(
  parameter int unsigned M            = 12,
  parameter int unsigned FRAME_CYCLES = 20,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic [3:0]  CH_MASK,
  input  logic        PRIO_REQ,
  input  logic [15:0] DATA_READ,
  output logic        SPI_RSTp,
  output logic        SPI_HOLD,
  output logic [1:0]  SPI_CH,
  output logic [M:0]  Vout,
  output logic [M:0]  Temp,
  output logic [M:0]  Vin,
  output logic [M:0]  Iout,
  output logic [3:0]  VALID,
  output logic        CH_ERR,
  output logic        BUSY
);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StCapt  = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;

  localparam int unsigned MaxA = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxB = (MaxA > RST_CYCLES) ? MaxA : RST_CYCLES;
  localparam int unsigned CntW = (MaxB < 2) ? 1 : $clog2(MaxB + 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      ch_q, ch_d;
  logic [1:0]      rr_q, rr_d;
  logic            prio_q, prio_d;
  logic            last0_q, last0_d;
  logic [3:0]      valid_q, valid_d;
  logic            err_q, err_d;
  logic [M:0]      res_q [4];

  logic [1:0]  rr_pick;
  logic [1:0]  idx;
  logic        found;
  logic        use_prio;
  logic [1:0]  sel_ch;
  logic        go;
  logic        decide;
  logic        cap_ok;
  logic [12:0] conv;
  logic        unused_bit15;

  assign unused_bit15 = DATA_READ[15];

  // Adding 2^12 mod 2^13 is the same as flipping the sign bit.
  assign conv = DATA_READ[12:0] ^ 13'h1000;

  // Next enabled channel after the round-robin pointer.
  always_comb begin
    rr_pick = rr_q;
    found   = 1'b0;
    idx     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && CH_MASK[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  end

  // A pending request wins unless the previous frame already sampled Vout, so
  // at most one Vout frame sits between round-robin frames of other channels.
  assign use_prio = (prio_q | PRIO_REQ) & CH_MASK[0] & ~last0_q;
  assign sel_ch   = use_prio ? 2'd0 : rr_pick;
  assign go       = EN & (|CH_MASK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    last0_d = last0_q;
    valid_d = 4'b0000;
    err_d   = 1'b0;
    cap_ok  = 1'b0;
    decide  = 1'b0;

    case (state_q)
      StInit: begin
        if (32'(cnt_q) + 32'd1 >= RST_CYCLES) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: decide = 1'b1;
      StStart: begin
        state_d = StWait;
        cnt_d   = CntW'(FRAME_CYCLES);
      end
      StWait: begin
        // DATA_READ is sampled on the edge entering capture, so the result
        // and its VALID/CH_ERR pulse are visible during the capture cycle.
        if (cnt_q == CntW'(1)) begin
          state_d = StCapt;
          if (DATA_READ[14:13] == ch_q) begin
            cap_ok        = 1'b1;
            valid_d[ch_q] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCapt: begin
        if (GAP_CYCLES == 0) begin
          decide = 1'b1;
        end else begin
          state_d = StGap;
          cnt_d   = CntW'(GAP_CYCLES);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(1)) begin
          decide = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StInit;
    endcase

    if (decide) begin
      if (go) begin
        state_d = StStart;
        ch_d    = sel_ch;
        last0_d = (sel_ch == 2'd0);
        if (!use_prio) begin
          rr_d = rr_pick;
        end
      end else begin
        state_d = StIdle;
      end
    end

    prio_d = prio_q | PRIO_REQ;
    if (decide && go && (sel_ch == 2'd0)) begin
      prio_d = 1'b0;
    end
    if (!CH_MASK[0]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ch_q    <= 2'd0;
      rr_q    <= 2'd3;
      prio_q  <= 1'b0;
      last0_q <= 1'b0;
      valid_q <= 4'b0000;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      prio_q  <= prio_d;
      last0_q <= last0_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (cap_ok) begin
        res_q[ch_q] <= conv[12 -: M+1];
      end
    end
  end

  assign SPI_RSTp = (state_q == StInit);
  assign SPI_HOLD = (state_q == StStart);
  assign BUSY     = (state_q == StStart) || (state_q == StWait) || (state_q == StCapt);
  assign SPI_CH   = ch_q;
  assign VALID    = valid_q;
  assign CH_ERR   = err_q;
  assign Vout     = res_q[0];
  assign Temp     = res_q[1];
  assign Vin      = res_q[2];
  assign Iout     = res_q[3];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized bench for adc_scan_scheduler. A frame-level reference model
// predicts frame start times, channel choice, results and pulses.
module tb_adc_scan_scheduler;

  localparam int F = 20;
  localparam int G = 2;
  localparam int R = 4;
  localparam int P = F + G + 2;

  logic        CLK;
  logic        RSTn;
  logic        EN;
  logic [3:0]  CH_MASK;
  logic        PRIO_REQ;
  logic [15:0] DATA_READ;

  logic        SPI_RSTp, SPI_HOLD, CH_ERR, BUSY;
  logic [1:0]  SPI_CH;
  logic [12:0] Vout, Temp, Vin, Iout;
  logic [3:0]  VALID;

  logic        n_rstp, n_hold, n_err, n_busy;
  logic [1:0]  n_ch;
  logic [7:0]  n_vout, n_temp, n_vin, n_iout;
  logic [3:0]  n_valid;

  adc_scan_scheduler dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .CH_MASK(CH_MASK), .PRIO_REQ(PRIO_REQ),
    .DATA_READ(DATA_READ), .SPI_RSTp(SPI_RSTp), .SPI_HOLD(SPI_HOLD), .SPI_CH(SPI_CH),
    .Vout(Vout), .Temp(Temp), .Vin(Vin), .Iout(Iout), .VALID(VALID), .CH_ERR(CH_ERR),
    .BUSY(BUSY)
  );

  adc_scan_scheduler #(.M(7)) dut7 (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .CH_MASK(CH_MASK), .PRIO_REQ(PRIO_REQ),
    .DATA_READ(DATA_READ), .SPI_RSTp(n_rstp), .SPI_HOLD(n_hold), .SPI_CH(n_ch),
    .Vout(n_vout), .Temp(n_temp), .Vin(n_vin), .Iout(n_iout), .VALID(n_valid),
    .CH_ERR(n_err), .BUSY(n_busy)
  );

  initial CLK = 1'b0;
  always #25 CLK = ~CLK;

  int n_cmp;
  int n_bad;
  int cyc;

  // Reference model state
  int          s;          // start cycle of the latest frame
  int          next_eval;  // next cycle whose inputs decide a frame start
  int          rr;
  bit          latch;
  bit          last0;
  logic [1:0]  m_ch;
  logic [15:0] fr_word;
  logic [12:0] m_res [4];

  int          seg_no;
  int          prio_mode;
  bit          zero_data;
  logic [12:0] pats [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset();
    check_eq("rst_rstp", 32'(SPI_RSTp), 32'd1);
    check_eq("rst_hold", 32'(SPI_HOLD), 32'd0);
    check_eq("rst_ch", 32'(SPI_CH), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_valid", 32'(VALID), 32'd0);
    check_eq("rst_err", 32'(CH_ERR), 32'd0);
    check_eq("rst_res", 32'({Vout, Temp, Vin}), 32'd0);
    check_eq("rst_iout", 32'(Iout), 32'd0);
    check_eq("rst_res7", {n_vout, n_temp, n_vin, n_iout}, 32'd0);
  endtask

  task automatic model_init();
    cyc       = 0;
    s         = -100;
    next_eval = R;
    rr        = 3;
    latch     = 1'b0;
    last0     = 1'b0;
    m_ch      = 2'd0;
    fr_word   = 16'h0;
    for (int i = 0; i < 4; i++) m_res[i] = 13'h0;
  endtask

  function automatic logic [3:0] pick_mask();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return 4'hF;
      1: return 4'b1010;
      2: return 4'b0000;
      3: return 4'b0001;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic new_segment();
    zero_data = 1'b0;
    case (seg_no)
      0: begin CH_MASK = 4'hF; prio_mode = 0; EN = 1'b1; zero_data = 1'b1; end
      1: begin CH_MASK = 4'b1010; prio_mode = 0; EN = 1'b1; end
      2: begin CH_MASK = 4'hF; prio_mode = 1; EN = 1'b1; end
      default: begin
        CH_MASK   = pick_mask();
        prio_mode = $urandom_range(0, 2);
        EN        = ($urandom_range(0, 9) != 0);
      end
    endcase
    seg_no++;
  endtask

  function automatic logic [15:0] make_word(input int ch);
    logic [1:0]  id;
    logic [12:0] d;
    id = 2'(ch);
    if (!zero_data && $urandom_range(0, 4) == 0) id = 2'($urandom);
    if (zero_data) d = 13'h0;
    else if ($urandom_range(0, 1) == 1) d = pats[$urandom_range(0, 3)];
    else d = 13'($urandom);
    return {1'($urandom), id, d};
  endfunction

  task automatic step();
    logic [3:0] vexp;
    bit         ok;
    bit         pend;
    bit         started;
    int         done_at;
    int         ch;
    int         d;

    // Stimulus for cycle cyc
    if (cyc % 150 == 0) new_segment();
    else if (seg_no > 3 && cyc % 150 == 75 && $urandom_range(0, 1) == 1) CH_MASK = pick_mask();
    PRIO_REQ  = (prio_mode == 1) || (prio_mode == 2 && $urandom_range(0, 22) == 0);
    DATA_READ = (cyc == s + F) ? fr_word : 16'($urandom);

    @(negedge CLK);

    done_at = s + F + 1;
    ok      = (fr_word[14:13] == m_ch);
    if (cyc == done_at && ok) begin
      d           = int'(fr_word[12:0]);
      m_res[m_ch] = 13'((d + 4096) % 8192);
    end
    vexp = (cyc == done_at && ok) ? 4'(1 << m_ch) : 4'b0000;

    check_eq("spi_rstp", 32'(SPI_RSTp), 32'(cyc < R));
    check_eq("spi_hold", 32'(SPI_HOLD), 32'(cyc == s));
    check_eq("busy", 32'(BUSY), 32'(cyc >= s && cyc <= done_at));
    check_eq("spi_ch", 32'(SPI_CH), 32'(m_ch));
    check_eq("valid", 32'(VALID), 32'(vexp));
    check_eq("ch_err", 32'(CH_ERR), 32'(cyc == done_at && !ok));
    check_eq("vout", 32'(Vout), 32'(m_res[0]));
    check_eq("temp", 32'(Temp), 32'(m_res[1]));
    check_eq("vin", 32'(Vin), 32'(m_res[2]));
    check_eq("iout", 32'(Iout), 32'(m_res[3]));
    check_eq("res_m7", {n_vout, n_temp, n_vin, n_iout},
             {8'(m_res[0] >> 5), 8'(m_res[1] >> 5), 8'(m_res[2] >> 5), 8'(m_res[3] >> 5)});

    // Frame-level decision using this cycle's inputs
    started = 1'b0;
    ch      = 0;
    if (cyc == next_eval) begin
      if (EN && CH_MASK != 4'b0000) begin
        pend = latch || PRIO_REQ;
        if (pend && CH_MASK[0] && !last0) begin
          ch = 0;
        end else begin
          ch = rr;
          for (int k = 1; k <= 4; k++) begin
            if (CH_MASK[(rr + k) % 4]) begin
              ch = (rr + k) % 4;
              break;
            end
          end
          rr = ch;
        end
        started   = 1'b1;
        last0     = (ch == 0);
        m_ch      = 2'(ch);
        s         = cyc + 1;
        next_eval = cyc + P;
        fr_word   = make_word(ch);
      end else begin
        next_eval = cyc + 1;
      end
    end
    if (!CH_MASK[0]) latch = 1'b0;
    else if (started && ch == 0) latch = 1'b0;
    else if (PRIO_REQ) latch = 1'b1;

    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    int guard;
    n_cmp     = 0;
    n_bad     = 0;
    seg_no    = 0;
    prio_mode = 0;
    zero_data = 1'b0;
    pats[0]   = 13'h1FFF;
    pats[1]   = 13'h0FFF;
    pats[2]   = 13'h1000;
    pats[3]   = 13'h0000;
    RSTn      = 1'b0;
    EN        = 1'b0;
    CH_MASK   = 4'h0;
    PRIO_REQ  = 1'b0;
    DATA_READ = 16'h0;
    model_init();

    #60;
    check_reset();

    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    model_init();
    repeat (2000) step();

    // Abort in the middle of a frame's wait phase
    guard = 0;
    while (!(cyc > s + 1 && cyc < s + F) && guard < 400) begin
      step();
      guard++;
    end
    check_eq("abort_reached", 32'(cyc > s + 1 && cyc < s + F), 32'd1);
    RSTn = 1'b0;
    #1;
    check_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset();
    RSTn = 1'b1;
    model_init();
    repeat (900) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
